// File: rtl/fifo_arb_pkg.sv
// Shared arbitration types and the round-robin search helper.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   rr_pick()   : first asserted request at or above ptr, wrapping modulo num
package fifo_arb_pkg;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   // The helper is sized for the widest arbiter that uses it; narrower callers zero-extend.
   localparam int unsigned RR_MAX_REQ = 8;
   localparam int unsigned RR_IDX_W   = 3;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // ptr must be < num. The candidate index is wrapped with a subtract, not a modulo,
   // so a non-power-of-2 requester count needs no divider.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                        input logic [RR_IDX_W-1:0]   ptr,
                                        input logic [RR_IDX_W:0]     num);
      rr_pick_t            res;
      logic [RR_IDX_W:0]   cand;
      res = '0;
      for (int k = 0; k < RR_MAX_REQ; k++) begin
         cand = {1'b0, ptr} + (RR_IDX_W + 1)'(k);
         if (cand >= num) begin
            cand = cand - num;
         end
         if (((RR_IDX_W + 1)'(k) < num) && !res.found && valid[cand[RR_IDX_W-1:0]]) begin
            res.found = 1'b1;
            res.idx   = cand[RR_IDX_W-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
//   valid_i  : request vector
//   ptr_i    : index with highest priority this round
//   onehot_o : selected request as a one-hot vector
//   index_o  : selected request index
//   any_o    : at least one request is asserted
module rr_priority_picker
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] onehot_o,
   output logic [IDX_W-1:0]   index_o,
   output logic               any_o
);

   logic [RR_MAX_REQ-1:0] valid_ext;
   rr_pick_t              pick;
   logic                  unused_idx_hi;

   always_comb begin
      valid_ext                = '0;
      valid_ext[NUM_REQ-1:0]   = valid_i;
      pick                     = rr_pick(valid_ext, RR_IDX_W'(ptr_i), (RR_IDX_W + 1)'(NUM_REQ));
      any_o                    = pick.found;
      index_o                  = pick.idx[IDX_W-1:0];
      onehot_o                 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         onehot_o[i] = pick.found && (pick.idx == RR_IDX_W'(i));
      end
   end

   assign unused_idx_hi = ^pick.idx;

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port between NUM_REQ packet sources.
// A grant is held until the owner's last word, or until MAX_BURST words (0 = no cap).
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/last/data   : per-requester word stream (requester i at [i*DW +: DW])
//   req_ready             : word accepted when valid & ready on the same edge
//   fifo_full             : FIFO full flag
//   fifo_w_en, fifo_data  : FIFO write port
//   grant_id              : current / last owner
//   busy                  : a grant is active
//   burst_cut             : sticky, a grant was force-released by the burst cap
module fifo_rr_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned MAX_BURST  = 64,
   localparam int unsigned IDX_W     = $clog2(NUM_REQ),
   localparam int unsigned CNT_W     = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_w_en,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   output logic [IDX_W-1:0]              grant_id,
   output logic                          busy,
   output logic                          burst_cut
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CAP_LAST = (MAX_BURST > 0) ? CNT_W'(MAX_BURST - 1) : '0;
   localparam bit               CAP_EN   = (MAX_BURST > 0);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] grant_id_q, grant_id_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic             burst_cut_q, burst_cut_d;
   logic             busy_q, busy_d;

   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               unused_onehot;

   logic accept;
   logic own_last;
   logic cap_hit;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .valid_i  (req_valid),
      .ptr_i    (rr_ptr_q),
      .onehot_o (pick_onehot),
      .index_o  (pick_idx),
      .any_o    (pick_any)
   );

   assign unused_onehot = ^pick_onehot;

   // Owner-to-FIFO path is purely combinational so a granted word costs no extra cycle.
   always_comb begin
      req_ready = '0;
      fifo_w_en = 1'b0;
      fifo_data = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
      if (state_q == GRANT) begin
         req_ready[grant_id_q] = !fifo_full;
         fifo_w_en             = req_valid[grant_id_q] & !fifo_full;
      end
   end

   assign accept   = fifo_w_en;
   assign own_last = req_last[grant_id_q];
   // This accepted word brings the count to MAX_BURST.
   assign cap_hit  = CAP_EN && (burst_cnt_q == CAP_LAST);

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      burst_cnt_d = burst_cnt_q;
      burst_cut_d = burst_cut_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_id_d  = pick_idx;
               burst_cnt_d = '0;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            if (accept) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
               if (own_last || cap_hit) begin
                  state_d  = IDLE;
                  rr_ptr_d = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + 1'b1;
                  // A last word landing exactly on the cap is a normal release.
                  if (!own_last) begin
                     burst_cut_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == GRANT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_id_q  <= '0;
         burst_cnt_q <= '0;
         burst_cut_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_id_q  <= grant_id_d;
         burst_cnt_q <= burst_cnt_d;
         burst_cut_q <= burst_cut_d;
         busy_q      <= busy_d;
      end
   end

   assign grant_id  = grant_id_q;
   assign busy      = busy_q;
   assign burst_cut = burst_cut_q;

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Directed bench for fifo_rr_write_arbiter (4 requesters, 16-bit words, burst cap of 4).
// Producers are modelled as per-requester word lists; every FIFO write and every new
// grant is logged and compared against hand-computed sequences.
module tb_fifo_rr_write_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 16;
   localparam int unsigned MB = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NR-1:0]  req_valid;
   logic [NR-1:0]  req_last;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]  req_ready;
   logic           fifo_full;
   logic           fifo_w_en;
   logic [DW-1:0]  fifo_data;
   logic [1:0]     grant_id;
   logic           busy;
   logic           burst_cut;

   always #5 clk = ~clk;

   fifo_rr_write_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data  (req_data),
      .req_ready (req_ready),
      .fifo_full (fifo_full),
      .fifo_w_en (fifo_w_en),
      .fifo_data (fifo_data),
      .grant_id  (grant_id),
      .busy      (busy),
      .burst_cut (burst_cut)
   );

   // Producer word lists
   logic [DW-1:0] src_data [NR][64];
   logic          src_last [NR][64];
   int            head [NR];
   int            tail [NR];

   // Observed and expected FIFO writes / grant sequence
   logic [DW-1:0] wlog [64];
   int            wtick [64];
   int            nlog;
   logic [DW-1:0] wexp [64];
   int            nexp;
   int            glog [16];
   int            ng;
   int            gexp [16];
   int            ngexp;

   int   tick_no;
   logic prev_busy;
   bit   rst_force;
   // Disturbance injected once nlog reaches stall_at: 1 = fifo_full, 2 = owner drops valid,
   // 3 = reset with all valid low.
   int   stall_at, stall_len, stall_kind, stall_req, stall_rem;
   bit   stall_done;

   int n_vec;
   int n_miss;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int r, input int p, input int w);
      return {4'(r), 4'(p), 8'(w)};
   endfunction

   task automatic load_pkt(input int r, input int p, input int first, input int n);
      for (int k = 0; k < n; k++) begin
         src_data[r][tail[r]] = mk(r, p, first + k);
         src_last[r][tail[r]] = (k == n - 1);
         tail[r]++;
      end
   endtask

   task automatic push_exp(input int r, input int p, input int first, input int n);
      for (int k = 0; k < n; k++) begin
         wexp[nexp] = mk(r, p, first + k);
         nexp++;
      end
   endtask

   task automatic push_g(input int g);
      gexp[ngexp] = g;
      ngexp++;
   endtask

   function automatic bit pending();
      bit p = 1'b0;
      for (int i = 0; i < NR; i++) begin
         if (head[i] < tail[i]) p = 1'b1;
      end
      return p;
   endfunction

   task automatic clear_logs();
      nlog = 0; nexp = 0; ng = 0; ngexp = 0;
      stall_done = 1'b1; stall_rem = 0;
   endtask

   task automatic arm_stall(input int kind, input int req, input int at, input int len);
      stall_kind = kind; stall_req = req; stall_at = at; stall_len = len; stall_done = 1'b0;
   endtask

   // One clock: drive after the edge, sample on the falling edge, retire after the next edge.
   task automatic tick();
      logic [NR-1:0] acc;
      logic [NR-1:0] others;
      bit            v;
      bit            st;
      st        = (stall_rem > 0);
      rst_n     = !(rst_force || (st && stall_kind == 3));
      fifo_full = st && (stall_kind == 1);
      for (int i = 0; i < NR; i++) begin
         v = (head[i] < tail[i]);
         if (st && ((stall_kind == 2 && i == stall_req) || stall_kind == 3)) v = 1'b0;
         req_valid[i]         = v;
         req_last[i]          = v ? src_last[i][head[i]] : 1'b0;
         req_data[i*DW +: DW] = v ? src_data[i][head[i]] : '0;
      end
      @(negedge clk);
      if (st) begin
         case (stall_kind)
            1: begin
               check_eq("full_w_en", 32'(fifo_w_en), 0);
               check_eq("full_cnt_held", 32'(dut.burst_cnt_q), 1);
            end
            2: begin
               others = req_ready;
               others[stall_req] = 1'b0;
               check_eq("drop_busy", 32'(busy), 1);
               check_eq("drop_grant", 32'(grant_id), 32'(stall_req));
               check_eq("drop_w_en", 32'(fifo_w_en), 0);
               check_eq("drop_other_ready", 32'(others), 0);
            end
            3: begin
               if (stall_rem == 1) begin
                  check_eq("rst_busy", 32'(busy), 0);
                  check_eq("rst_ready", 32'(req_ready), 0);
                  check_eq("rst_burst_cut", 32'(burst_cut), 0);
                  check_eq("rst_grant", 32'(grant_id), 0);
               end
            end
            default: ;
         endcase
         stall_rem--;
      end
      if (busy && !prev_busy) begin
         glog[ng] = int'(grant_id);
         ng++;
      end
      prev_busy = busy;
      acc = req_valid & req_ready;
      if (fifo_w_en) begin
         wlog[nlog]  = fifo_data;
         wtick[nlog] = tick_no;
         nlog++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (acc[i]) head[i]++;
      end
      tick_no++;
   endtask

   task automatic run(input string tag, input int max_ticks);
      int t = 0;
      while ((pending() || busy) && t < max_ticks) begin
         if (!stall_done && nlog == stall_at) begin
            stall_rem  = stall_len;
            stall_done = 1'b1;
         end
         tick();
         t++;
      end
      check_eq({tag, "_timeout"}, 32'(t >= max_ticks), 0);
   endtask

   task automatic check_results(input string tag);
      check_eq({tag, "_nwrites"}, 32'(nlog), 32'(nexp));
      for (int i = 0; i < nexp && i < nlog; i++) begin
         check_eq($sformatf("%s_data%0d", tag, i), 32'(wlog[i]), 32'(wexp[i]));
      end
      check_eq({tag, "_ngrants"}, 32'(ng), 32'(ngexp));
      for (int i = 0; i < ngexp && i < ng; i++) begin
         check_eq($sformatf("%s_grant%0d", tag, i), 32'(glog[i]), 32'(gexp[i]));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int t0;
      int early;
      n_vec = 0; n_miss = 0; tick_no = 0; prev_busy = 1'b0;
      for (int i = 0; i < NR; i++) begin
         head[i] = 0; tail[i] = 0;
      end
      rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
      clear_logs();
      rst_force = 1'b1;
      @(posedge clk);
      #1;

      // Reset with every requester valid (packets for the fairness test already queued)
      load_pkt(0, 0, 0, 2);
      load_pkt(0, 1, 0, 2);
      load_pkt(1, 0, 0, 2);
      load_pkt(2, 0, 0, 2);
      load_pkt(3, 0, 0, 2);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_eq("reset_ready", 32'(req_ready), 0);
         check_eq("reset_w_en", 32'(fifo_w_en), 0);
         check_eq("reset_busy", 32'(busy), 0);
      end
      check_eq("reset_grant", 32'(grant_id), 0);
      check_eq("reset_burst_cut", 32'(burst_cut), 0);
      rst_force = 1'b0;

      // Fairness: 2-word packets, grants 0,1,2,3,0; 2 words + 1 bubble per grant
      clear_logs();
      t0 = tick_no;
      run("fair", 100);
      push_exp(0, 0, 0, 2); push_exp(1, 0, 0, 2); push_exp(2, 0, 0, 2);
      push_exp(3, 0, 0, 2); push_exp(0, 1, 0, 2);
      push_g(0); push_g(1); push_g(2); push_g(3); push_g(0);
      check_results("fair");
      early = 0;
      for (int i = 0; i < nlog; i++) begin
         if (wtick[i] < t0 + 12) early++;
      end
      check_eq("fair_writes_12cyc", 32'(early), 8);

      // Backpressure mid-packet of requester 2
      clear_logs();
      load_pkt(2, 2, 0, 3);
      arm_stall(1, 2, 1, 5);
      run("bp", 100);
      push_exp(2, 2, 0, 3);
      push_g(2);
      check_results("bp");
      check_eq("bp_burst_cut", 32'(burst_cut), 0);

      // Last word exactly at the cap: normal release; pointer then wraps 3 -> 0
      clear_logs();
      load_pkt(3, 3, 0, 4);
      run("caplast", 100);
      push_exp(3, 3, 0, 4);
      push_g(3);
      check_results("caplast");
      check_eq("caplast_burst_cut", 32'(burst_cut), 0);

      // Owner drops valid for 3 cycles; grant is held while requester 3 waits
      clear_logs();
      load_pkt(0, 4, 0, 3);
      load_pkt(3, 5, 0, 1);
      arm_stall(2, 0, 1, 3);
      run("drop", 100);
      push_exp(0, 4, 0, 3); push_exp(3, 5, 0, 1);
      push_g(0); push_g(3);
      check_results("drop");

      // Burst cap: 10-word packet from requester 1 is split 4 / 4 / 2 around requester 3
      clear_logs();
      load_pkt(1, 6, 0, 10);
      load_pkt(3, 7, 0, 2);
      run("cap", 200);
      push_exp(1, 6, 0, 4); push_exp(3, 7, 0, 2); push_exp(1, 6, 4, 4); push_exp(1, 6, 8, 2);
      push_g(1); push_g(3); push_g(1); push_g(1);
      check_results("cap");
      check_eq("cap_burst_cut", 32'(burst_cut), 1);

      // Reset after 2 of 5 words; fresh arbitration starts from requester 0
      clear_logs();
      load_pkt(2, 8, 0, 5);
      load_pkt(0, 9, 0, 1);
      arm_stall(3, 0, 2, 2);
      run("midrst", 100);
      push_exp(2, 8, 0, 2); push_exp(0, 9, 0, 1); push_exp(2, 8, 2, 3);
      push_g(2); push_g(0); push_g(2);
      check_results("midrst");
      check_eq("midrst_burst_cut", 32'(burst_cut), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
